// File: rtl/ahbl_simple_master_pkg.sv
// Shared AHB-lite encodings, request sizes and FSM state type for the simple
// single-transfer AHB-lite master.
package ahbl_simple_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR,
    ST_DONE
  } state_t;

  // Rejects size 3 and any access not naturally aligned to its size.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lsb[0];
      HSIZE_WORD: bad = (addr_lsb != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahbl_simple_master_if.sv
// AHB-lite bus bundle between the simple master and a slave; the master
// modport drives address/control/write data, the slave modport returns data and status.
interface ahbl_simple_master_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [W_ADDR-1:0] ahbm_haddr;
  logic              ahbm_hwrite;
  logic [1:0]        ahbm_htrans;
  logic [2:0]        ahbm_hsize;
  logic [2:0]        ahbm_hburst;
  logic [3:0]        ahbm_hprot;
  logic              ahbm_hmastlock;
  logic [W_DATA-1:0] ahbm_hwdata;
  logic              ahbm_hexcl;
  logic [7:0]        ahbm_hmaster;
  logic [W_DATA-1:0] ahbm_hrdata;
  logic              ahbm_hready;
  logic              ahbm_hresp;
  logic              ahbm_hexokay;

  modport master (
    output ahbm_haddr, ahbm_hwrite, ahbm_htrans, ahbm_hsize, ahbm_hburst, ahbm_hprot,
           ahbm_hmastlock, ahbm_hwdata, ahbm_hexcl, ahbm_hmaster,
    input  ahbm_hrdata, ahbm_hready, ahbm_hresp, ahbm_hexokay
  );

  modport slave (
    input  ahbm_haddr, ahbm_hwrite, ahbm_htrans, ahbm_hsize, ahbm_hburst, ahbm_hprot,
           ahbm_hmastlock, ahbm_hwdata, ahbm_hexcl, ahbm_hmaster,
    output ahbm_hrdata, ahbm_hready, ahbm_hresp, ahbm_hexokay
  );
endinterface

// File: rtl/ahbl_simple_master_lane_align.sv
// Combinational byte-lane helper: replicates write data across lanes and
// extracts right-justified, zero-extended read data from size + addr[1:0].
module ahbl_lane_align
  import ahbl_simple_master_pkg::*;
#(
  parameter int W_DATA = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lsb,
  input  logic [W_DATA-1:0] wdata,
  input  logic [W_DATA-1:0] rdata,
  output logic [W_DATA-1:0] wr_lanes,
  output logic [W_DATA-1:0] rd_value
);

  logic [W_DATA-1:0] byte_rep;
  logic [W_DATA-1:0] half_rep;
  logic [W_DATA-1:0] rd_shifted;

  genvar gi;
  generate
    for (gi = 0; gi < W_DATA / 8; gi++) begin : g_byte_rep
      assign byte_rep[gi*8 +: 8] = wdata[7:0];
    end
    for (gi = 0; gi < W_DATA / 16; gi++) begin : g_half_rep
      assign half_rep[gi*16 +: 16] = wdata[15:0];
    end
  endgenerate

  // Aligned accesses only reach here, so shifting by the byte offset lands the lane at bit 0.
  assign rd_shifted = rdata >> {addr_lsb, 3'b000};

  always_comb begin
    wr_lanes = wdata;
    rd_value = rd_shifted;
    case (size)
      HSIZE_BYTE: begin
        wr_lanes = byte_rep;
        rd_value = {{(W_DATA-8){1'b0}}, rd_shifted[7:0]};
      end
      HSIZE_HALF: begin
        wr_lanes = half_rep;
        rd_value = {{(W_DATA-16){1'b0}}, rd_shifted[15:0]};
      end
      default: begin
        wr_lanes = wdata;
        rd_value = rd_shifted;
      end
    endcase
  end

endmodule

// File: rtl/ahbl_simple_master.sv
// Single-outstanding AHB-lite master turning rd/wr requests into NONSEQ SINGLE transfers.
// Define AHBL_MASTER_EXCL_EN to enable exclusive-access signalling (hexcl / o_exokay).
module ahbl_simple_master
  import ahbl_simple_master_pkg::*;
#(
  parameter int          W_ADDR    = 32,
  parameter int          W_DATA    = 32,
  parameter logic [7:0]  MASTER_ID = 8'h01,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  input  logic [W_ADDR-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_excl,
  output logic              o_busy,
  output logic              o_valid,
  output logic              o_err,
  output logic [W_DATA-1:0] o_data,
  output logic              o_exokay,
  ahbl_simple_master_if.master bus
);

`ifdef AHBL_MASTER_EXCL_EN
  localparam logic EXCL_ON = 1'b1;
`else
  localparam logic EXCL_ON = 1'b0;
`endif

  state_t            state_reg;
  logic [1:0]        htrans_reg;
  logic [W_ADDR-1:0] haddr_reg;
  logic              hwrite_reg;
  logic [2:0]        hsize_reg;
  logic [W_DATA-1:0] hwdata_reg;
  logic              hexcl_reg;
  logic              excl_reg;
  logic [W_DATA-1:0] wdata_lat_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic              err_reg;
  logic [W_DATA-1:0] data_reg;
  logic              exokay_reg;

  logic [W_DATA-1:0] wr_lanes;
  logic [W_DATA-1:0] rd_value;

  ahbl_lane_align #(.W_DATA(W_DATA)) u_lane_align (
    .size     (hsize_reg[1:0]),
    .addr_lsb (haddr_reg[1:0]),
    .wdata    (wdata_lat_reg),
    .rdata    (bus.ahbm_hrdata),
    .wr_lanes (wr_lanes),
    .rd_value (rd_value)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      htrans_reg    <= HTRANS_IDLE;
      haddr_reg     <= '0;
      hwrite_reg    <= 1'b0;
      hsize_reg     <= '0;
      hwdata_reg    <= '0;
      hexcl_reg     <= 1'b0;
      excl_reg      <= 1'b0;
      wdata_lat_reg <= '0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      data_reg      <= '0;
      exokay_reg    <= 1'b0;
    end else begin
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      exokay_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_rd_en || i_wr_en) begin
            if ((i_rd_en && i_wr_en) || req_illegal(i_size, i_addr[1:0])) begin
              // Rejected locally: the bus never sees it, completion reports an error.
              valid_reg <= 1'b1;
              err_reg   <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              haddr_reg     <= i_addr;
              hwrite_reg    <= i_wr_en;
              hsize_reg     <= {1'b0, i_size};
              wdata_lat_reg <= i_data;
              excl_reg      <= i_excl & EXCL_ON;
              hexcl_reg     <= i_excl & EXCL_ON;
              htrans_reg    <= HTRANS_NONSEQ;
              busy_reg      <= 1'b1;
              state_reg     <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (bus.ahbm_hready) begin
            htrans_reg <= HTRANS_IDLE;
            hexcl_reg  <= 1'b0;
            hwdata_reg <= wr_lanes;
            state_reg  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.ahbm_hready) begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= ST_DONE;
            if (bus.ahbm_hresp) begin
              err_reg <= 1'b1;
            end else begin
              if (!hwrite_reg) begin
                data_reg <= rd_value;
              end
              exokay_reg <= bus.ahbm_hexokay & excl_reg;
            end
          end else if (bus.ahbm_hresp) begin
            state_reg <= ST_ERR;
          end
        end
        ST_ERR: begin
          // Second cycle of the two-cycle ERROR response completes the transfer.
          if (bus.ahbm_hready) begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b1;
            err_reg   <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = busy_reg;
  assign o_valid  = valid_reg;
  assign o_err    = err_reg;
  assign o_data   = data_reg;
  assign o_exokay = exokay_reg;

  assign bus.ahbm_haddr     = haddr_reg;
  assign bus.ahbm_hwrite    = hwrite_reg;
  assign bus.ahbm_htrans    = htrans_reg;
  assign bus.ahbm_hsize     = hsize_reg;
  assign bus.ahbm_hburst    = HBURST_SINGLE;
  assign bus.ahbm_hprot     = HPROT_VAL;
  assign bus.ahbm_hmastlock = 1'b0;
  assign bus.ahbm_hwdata    = hwdata_reg;
  assign bus.ahbm_hexcl     = hexcl_reg;
  assign bus.ahbm_hmaster   = MASTER_ID;

endmodule

// File: tb/tb_ahbl_simple_master.sv
// Table-driven bench for ahbl_simple_master with a behavioural AHB-lite slave
// and a scoreboard of expected completions (AHBL_MASTER_EXCL_EN aware).
module tb_ahbl_simple_master;

`ifdef AHBL_MASTER_EXCL_EN
  localparam bit EXCL_ON = 1'b1;
`else
  localparam bit EXCL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rd_en, i_wr_en, i_excl;
  logic [31:0] i_addr, i_data;
  logic [1:0]  i_size;
  logic        o_busy, o_valid, o_err, o_exokay;
  logic [31:0] o_data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ahbl_simple_master_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  ahbl_simple_master dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_en  (i_rd_en),
    .i_wr_en  (i_wr_en),
    .i_addr   (i_addr),
    .i_size   (i_size),
    .i_data   (i_data),
    .i_excl   (i_excl),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_data   (o_data),
    .o_exokay (o_exokay),
    .bus      (bus.master)
  );

  // Slave model: configured per transaction; all outputs change on the falling edge.
  logic [31:0] s_rdata = '0;
  int          s_waits = 0;
  bit          s_err = 0;
  bit          s_exok = 0;
  bit          dphase = 0;
  bit          addr_done = 0;
  int          dcnt = 0;
  int          estage = 0;

  initial begin
    bus.ahbm_hready  = 1'b1;
    bus.ahbm_hresp   = 1'b0;
    bus.ahbm_hrdata  = '0;
    bus.ahbm_hexokay = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      dphase = 0;
    end else begin
      if (dphase && bus.ahbm_hready) dphase = 0;
      else if (dphase) begin
        if (dcnt > 0) dcnt--;
        else estage++;
      end
      if (addr_done) begin
        dphase = 1; dcnt = s_waits; estage = 0;
      end
    end
    bus.ahbm_hrdata  = '0;
    bus.ahbm_hexokay = 1'b0;
    if (!dphase) begin
      bus.ahbm_hready = 1'b1; bus.ahbm_hresp = 1'b0;
    end else if (dcnt > 0) begin
      bus.ahbm_hready = 1'b0; bus.ahbm_hresp = 1'b0;
    end else if (s_err) begin
      bus.ahbm_hready = (estage >= 1); bus.ahbm_hresp = 1'b1;
    end else begin
      bus.ahbm_hready = 1'b1; bus.ahbm_hresp = 1'b0;
      bus.ahbm_hrdata = s_rdata; bus.ahbm_hexokay = s_exok;
    end
    addr_done = (bus.ahbm_htrans == 2'b10) && bus.ahbm_hready;
  end

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    bit          excl;
    logic [31:0] srdata;
    int          waits;
    bit          serr;
    bit          sexok;
    bit          poke;
    logic [31:0] exp_data;
    logic [31:0] exp_hw;
  } vec_t;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          lat;
    bit          exok;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_illegal(input vec_t v);
    if (v.rd && v.wr) return 1;
    case (v.size)
      2'd0: return 0;
      2'd1: return v.addr[0];
      2'd2: return v.addr[1:0] != 2'b00;
      default: return 1;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    bit   ill, done;
    ill = is_illegal(v);
    e.err  = ill || v.serr;
    e.data = v.exp_data;
    e.lat  = ill ? 1 : (v.serr ? 4 + v.waits : 3 + v.waits);
    e.exok = EXCL_ON && v.excl && v.sexok && !e.err;
    @(negedge clk);
    s_rdata = v.srdata; s_waits = v.waits; s_err = v.serr; s_exok = v.sexok;
    i_rd_en = v.rd; i_wr_en = v.wr; i_addr = v.addr; i_size = v.size;
    i_data = v.wdata; i_excl = v.excl;
    sb.push_back(e);
    done = 0;
    for (int k = 1; k <= 30 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_rd_en = 0; i_wr_en = 0; i_excl = 0;
      end
      if (v.poke && k == 2) begin
        i_wr_en = 1; i_addr = 32'h0;
      end
      if (v.poke && k == 3) i_wr_en = 0;
      chk("htrans_legal", 32'(bus.ahbm_htrans == 2'b00 || bus.ahbm_htrans == 2'b10), 32'd1);
      if (k == 1) begin
        chk("htrans_t1", 32'(bus.ahbm_htrans), ill ? 32'd0 : 32'd2);
        if (!ill) begin
          chk("haddr", bus.ahbm_haddr, v.addr);
          chk("hsize", 32'(bus.ahbm_hsize), 32'(v.size));
          chk("hwrite", 32'(bus.ahbm_hwrite), 32'(v.wr));
          chk("hexcl_addr", 32'(bus.ahbm_hexcl), 32'(EXCL_ON && v.excl));
          chk("busy_t1", 32'(o_busy), 32'd1);
        end
      end
      if (!ill && k == 2) chk("hexcl_data", 32'(bus.ahbm_hexcl), 32'd0);
      if (!ill && v.wr && k >= 2 && k < e.lat) chk("hwdata", bus.ahbm_hwdata, v.exp_hw);
      if (o_valid) begin
        done = 1;
        $display("txn %0d: rd=%0b wr=%0b addr=%08h size=%0d err=%0b data=%08h exokay=%0b cycles=%0d",
                 idx, v.rd, v.wr, v.addr, v.size, o_err, o_data, o_exokay, k);
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk("latency", k, got.lat);
          chk("o_err", 32'(o_err), 32'(got.err));
          chk("o_data", o_data, got.data);
          chk("o_exokay", 32'(o_exokay), 32'(got.exok));
          chk("busy_done", 32'(o_busy), 32'd0);
        end
      end
    end
    if (!done) begin
      chk("valid_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [1:0] size,
                              logic [31:0] wdata, bit excl, logic [31:0] srdata, int waits,
                              bit serr, bit sexok, bit poke, logic [31:0] exp_data,
                              logic [31:0] exp_hw);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.excl = excl;
    v.srdata = srdata; v.waits = waits; v.serr = serr; v.sexok = sexok; v.poke = poke;
    v.exp_data = exp_data; v.exp_hw = exp_hw;
    return v;
  endfunction

  initial begin
    //             rd wr addr          sz wdata         ex srdata        wt er xo pk exp_data      exp_hw
    vecs[0]  = mk(1, 0, 32'h100, 2'd2, 32'h0,        0, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(0, 1, 32'h103, 2'd0, 32'hA5,       0, 32'h0,        2, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5);
    vecs[2]  = mk(1, 0, 32'h102, 2'd1, 32'h0,        0, 32'h12345678, 0, 0, 0, 0, 32'h00001234, 32'h0);
    vecs[3]  = mk(0, 1, 32'h200, 2'd2, 32'hCAFEF00D, 0, 32'h0,        0, 1, 0, 0, 32'h00001234, 32'hCAFEF00D);
    vecs[4]  = mk(1, 0, 32'h101, 2'd2, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h00001234, 32'h0);
    vecs[5]  = mk(1, 1, 32'h0,   2'd2, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h00001234, 32'h0);
    vecs[6]  = mk(1, 0, 32'h10,  2'd3, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h00001234, 32'h0);
    vecs[7]  = mk(1, 0, 32'h101, 2'd0, 32'h0,        0, 32'h11223344, 0, 0, 0, 0, 32'h00000033, 32'h0);
    vecs[8]  = mk(0, 1, 32'h002, 2'd1, 32'hBEEF,     0, 32'h0,        0, 0, 0, 0, 32'h00000033, 32'hBEEFBEEF);
    vecs[9]  = mk(1, 0, 32'h001, 2'd1, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h00000033, 32'h0);
    vecs[10] = mk(1, 0, 32'h103, 2'd0, 32'h0,        0, 32'hAABBCCDD, 1, 0, 0, 0, 32'h000000AA, 32'h0);
    vecs[11] = mk(1, 0, 32'h500, 2'd2, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h000000AA, 32'h0);
    vecs[12] = mk(0, 1, 32'h300, 2'd2, 32'h01020304, 1, 32'h0,        0, 0, 1, 0, 32'h000000AA, 32'h01020304);
    vecs[13] = mk(1, 0, 32'h104, 2'd2, 32'h0,        0, 32'h0BADF00D, 0, 0, 0, 1, 32'h0BADF00D, 32'h0);

    rst_n = 0; i_rd_en = 0; i_wr_en = 0; i_excl = 0;
    i_addr = '0; i_data = '0; i_size = '0;
    repeat (3) @(negedge clk);
    chk("rst_htrans", 32'(bus.ahbm_htrans), 32'd0);
    chk("rst_haddr", bus.ahbm_haddr, 32'd0);
    chk("rst_hwdata", bus.ahbm_hwdata, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_odata", o_data, 32'd0);
    chk("hburst", 32'(bus.ahbm_hburst), 32'd0);
    chk("hprot", 32'(bus.ahbm_hprot), 32'h3);
    chk("hmaster", 32'(bus.ahbm_hmaster), 32'h01);
    chk("hmastlock", 32'(bus.ahbm_hmastlock), 32'd0);
    rst_n = 1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // The write poked in during vector 13 must have been dropped.
    repeat (3) begin
      @(negedge clk);
      chk("ignored_htrans", 32'(bus.ahbm_htrans), 32'd0);
      chk("ignored_valid", 32'(o_valid), 32'd0);
    end

    // Reset asserted while the address phase is on the bus.
    i_rd_en = 1; i_addr = 32'h400; i_size = 2'd2; i_excl = 1;
    @(negedge clk);
    i_rd_en = 0; i_excl = 0;
    chk("midrst_nonseq", 32'(bus.ahbm_htrans), 32'd2);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_htrans", 32'(bus.ahbm_htrans), 32'd0);
    chk("midrst_haddr", bus.ahbm_haddr, 32'd0);
    chk("midrst_hsize", 32'(bus.ahbm_hsize), 32'd0);
    chk("midrst_hexcl", 32'(bus.ahbm_hexcl), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_odata", o_data, 32'd0);
    rst_n = 1;

    run_vec(mk(1, 0, 32'h8, 2'd2, 32'h0, 0, 32'h55AA55AA, 0, 0, 0, 0, 32'h55AA55AA, 32'h0), 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
